// File: rtl/pc_stack.sv
// Program counter with increment, relative branch, absolute jump and
// subroutine call/return through an internal hardware return stack.
module pc_stack #(
   parameter int unsigned p_size  = 6,
   parameter int unsigned p_depth = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_incr,
   input  logic              pc_relbranch,
   input  logic              pc_jump,
   input  logic              pc_call,
   input  logic              pc_ret,
   input  logic [p_size-1:0] branch_addr,
   output logic [p_size-1:0] pc_out,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              stack_err
);

   localparam int unsigned     CW      = $clog2(p_depth + 1);
   localparam logic [CW-1:0]   C_DEPTH = CW'(p_depth);
   localparam logic [p_size-1:0] C_ONE = p_size'(1);

   logic [p_size-1:0] r_pc;
   logic [CW-1:0]     r_count;
   logic              r_err;
   logic [p_size-1:0] r_stack [p_depth];

   logic [p_size-1:0] w_pc_next;
   logic [CW-1:0]     w_count_next;
   logic              w_err_next;
   logic              w_push;
   logic [p_size-1:0] w_top;
   logic [p_size-1:0] w_pc_plus1;

   assign w_pc_plus1 = r_pc + C_ONE;

   // Top-of-stack select by compare avoids indexing with an over-wide pointer.
   always_comb begin
      w_top = '0;
      for (int unsigned i = 0; i < p_depth; i++) begin
         if (r_count == CW'(i + 1)) w_top = r_stack[i];
      end
   end

   always_comb begin
      w_pc_next    = r_pc;
      w_count_next = r_count;
      w_err_next   = r_err;
      w_push       = 1'b0;
      if (pc_ret) begin
         if (r_count != '0) begin
            w_pc_next    = w_top;
            w_count_next = r_count - CW'(1);
         end else begin
            w_err_next   = 1'b1;
         end
      end else if (pc_call) begin
         if (r_count != C_DEPTH) begin
            w_push       = 1'b1;
            w_count_next = r_count + CW'(1);
            w_pc_next    = branch_addr;
         end else begin
            w_err_next   = 1'b1;
         end
      end else if (pc_jump) begin
         w_pc_next = branch_addr;
      end else if (pc_relbranch) begin
         w_pc_next = r_pc + branch_addr;
      end else if (pc_incr) begin
         w_pc_next = w_pc_plus1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
         for (int unsigned i = 0; i < p_depth; i++) r_stack[i] <= '0;
      end else begin
         r_pc    <= w_pc_next;
         r_count <= w_count_next;
         r_err   <= w_err_next;
         for (int unsigned i = 0; i < p_depth; i++) begin
            if (w_push && r_count == CW'(i)) r_stack[i] <= w_pc_plus1;
         end
      end
   end

   assign pc_out      = r_pc;
   assign stack_empty = (r_count == '0);
   assign stack_full  = (r_count == C_DEPTH);
   assign stack_err   = r_err;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: stimulus pushes expected state from a
// queue-based reference model; a monitor pops and compares after each edge.
module tb_pc_stack;

   localparam int P_SIZE  = 6;
   localparam int P_DEPTH = 4;
   localparam int MODN    = 1 << P_SIZE;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              pc_incr = 1'b0, pc_relbranch = 1'b0, pc_jump = 1'b0;
   logic              pc_call = 1'b0, pc_ret = 1'b0;
   logic [P_SIZE-1:0] branch_addr = '0;
   logic [P_SIZE-1:0] pc_out;
   logic              stack_empty, stack_full, stack_err;

   pc_stack #(.p_size(P_SIZE), .p_depth(P_DEPTH)) dut (
      .clk(clk), .reset(reset), .pc_incr(pc_incr), .pc_relbranch(pc_relbranch),
      .pc_jump(pc_jump), .pc_call(pc_call), .pc_ret(pc_ret),
      .branch_addr(branch_addr), .pc_out(pc_out), .stack_empty(stack_empty),
      .stack_full(stack_full), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    pc;
      bit    empty;
      bit    full;
      bit    err;
      string tag;
   } exp_t;

   exp_t q[$];
   event ev_rst;
   int   n_vec = 0;
   int   n_bad = 0;

   // reference model
   int m_pc;
   int m_stk[$];
   bit m_err;

   function automatic void model_reset();
      m_pc = 0;
      m_stk.delete();
      m_err = 0;
   endfunction

   function automatic void model_step(bit r, bit c, bit j, bit b, bit i, int a);
      if (r) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else m_err = 1;
      end else if (c) begin
         if (m_stk.size() < P_DEPTH) begin
            m_stk.push_back((m_pc + 1) % MODN);
            m_pc = a;
         end else m_err = 1;
      end else if (j) m_pc = a;
      else if (b) m_pc = (m_pc + a) % MODN;
      else if (i) m_pc = (m_pc + 1) % MODN;
   endfunction

   function automatic exp_t model_exp(string tag);
      exp_t e;
      e.pc = m_pc;
      e.empty = (m_stk.size() == 0);
      e.full = (m_stk.size() == P_DEPTH);
      e.err = m_err;
      e.tag = tag;
      return e;
   endfunction

   task automatic cmd(input bit r, input bit c, input bit j, input bit b,
                      input bit i, input int a, input string tag);
      @(negedge clk);
      pc_ret = r; pc_call = c; pc_jump = j; pc_relbranch = b; pc_incr = i;
      branch_addr = P_SIZE'(a);
      model_step(r, c, j, b, i, a);
      q.push_back(model_exp(tag));
   endtask

   // Reset raised while the clock is low; its effect is checked before the next edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      pc_ret = 0; pc_call = 0; pc_jump = 0; pc_relbranch = 0; pc_incr = 0;
      reset = 1'b1;
      model_reset();
      q.push_back(model_exp("reset"));
      ->ev_rst;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk or ev_rst);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (int'(pc_out) != e.pc || stack_empty != e.empty ||
                stack_full != e.full || stack_err != e.err) begin
               n_bad++;
               $display("FAIL %s: got pc=%0d empty=%0b full=%0b err=%0b, expected pc=%0d empty=%0b full=%0b err=%0b",
                        e.tag, pc_out, stack_empty, stack_full, stack_err,
                        e.pc, e.empty, e.full, e.err);
            end
         end
      end
   end

   initial begin : stim
      do_reset();
      // 1: full-range increment and wrap
      for (int k = 0; k < 63; k++) cmd(0, 0, 0, 0, 1, 0, "incr");
      cmd(0, 0, 0, 0, 1, 0, "incr_wrap");
      // 2: negative and wrapping relative branches
      cmd(0, 0, 1, 0, 0, 20, "jump20");
      cmd(0, 0, 0, 1, 0, 'h36, "rel_neg10");
      cmd(0, 0, 0, 1, 0, 60, "rel_wrap");
      // 3: nested call/return
      cmd(0, 0, 1, 0, 0, 3, "jump3");
      cmd(0, 1, 0, 0, 0, 8, "call8");
      cmd(0, 1, 0, 0, 0, 16, "call16");
      cmd(1, 0, 0, 0, 0, 0, "ret1");
      cmd(1, 0, 0, 0, 0, 0, "ret2");
      // 4: fill, overflow, drain
      for (int k = 1; k <= 4; k++) cmd(0, 1, 0, 0, 0, k, "call_fill");
      cmd(0, 1, 0, 0, 0, 50, "call_overflow");
      for (int k = 0; k < 4; k++) cmd(1, 0, 0, 0, 0, 0, "ret_drain");
      // 5: underflow is sticky through legal commands
      do_reset();
      cmd(1, 0, 0, 0, 0, 0, "ret_underflow");
      cmd(0, 0, 1, 0, 0, 12, "jump_after_err");
      // 6: priority, then asynchronous reset mid-sequence
      do_reset();
      cmd(0, 0, 1, 0, 0, 6, "jump6");
      cmd(0, 1, 0, 0, 0, 40, "call_push7");
      cmd(1, 1, 0, 0, 1, 33, "ret_call_incr");
      cmd(0, 1, 1, 1, 1, 21, "call_over_rest");
      cmd(0, 0, 1, 1, 1, 9, "jump_over_rest");
      cmd(0, 0, 0, 1, 1, 5, "rel_over_incr");
      cmd(0, 0, 0, 0, 0, 0, "idle_hold");
      do_reset();
      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         else cmd($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, MODN - 1)),
                  "random");
      end
      cmd(0, 0, 0, 0, 0, 0, "final_idle");
      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
